// File: rtl/retire_trace_buffer.sv
// rtl/retire_trace_buffer.sv - circular trace of retired instructions with PC trigger and post-trigger window
// Optional timestamping: define TRACE_TIMESTAMP_EN to add a cycle counter and rd_cycle.
module retire_trace_buffer #(
   parameter int DEPTH = 16,
   parameter int XLEN  = 32,
   parameter int CYC_W = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic                       mode_wrap,
   input  logic                       trig_en,
   input  logic [XLEN-1:0]            trig_pc,
   input  logic [$clog2(DEPTH):0]     post_cnt,
   input  logic                       ret_valid,
   input  logic [XLEN-1:0]            ret_pc,
   input  logic [XLEN-1:0]            ret_instr,
   input  logic [4:0]                 ret_rd,
   input  logic                       ret_we,
   input  logic [XLEN-1:0]            ret_wdata,
   output logic                       rd_valid,
   input  logic                       rd_ready,
   output logic [XLEN-1:0]            rd_pc,
   output logic [XLEN-1:0]            rd_instr,
   output logic [XLEN-1:0]            rd_wdata,
   output logic [4:0]                 rd_rd,
   output logic                       rd_we,
`ifdef TRACE_TIMESTAMP_EN
   output logic [CYC_W-1:0]           rd_cycle,
`endif
   output logic [$clog2(DEPTH):0]     count,
   output logic [1:0]                 state,
   output logic                       overflow,
   output logic                       triggered
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_POST    = 2'd2,
      ST_DONE    = 2'd3
   } state_e;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("DEPTH must be a power of 2 and at least 2");
   end

   state_e          state_q, state_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d, remain_q, remain_d;
   logic            overflow_q, overflow_d, triggered_q, triggered_d;
   logic            push, pop, full, flush, mem_we;

   logic [XLEN-1:0] pc_mem    [DEPTH];
   logic [XLEN-1:0] instr_mem [DEPTH];
   logic [XLEN-1:0] wdata_mem [DEPTH];
   logic [4:0]      rd_mem    [DEPTH];
   logic            we_mem    [DEPTH];

   assign flush = (state_q == ST_IDLE) && en;
   assign full  = (count_q == CW'(DEPTH));
   assign push  = ret_valid && ((state_q == ST_CAPTURE) || (state_q == ST_POST));
   assign pop   = rd_valid && rd_ready && !flush;

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      remain_d    = remain_q;
      overflow_d  = overflow_q;
      triggered_d = triggered_q;
      mem_we      = 1'b0;
      if (flush) begin
         state_d     = ST_CAPTURE;
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         overflow_d  = 1'b0;
         triggered_d = 1'b0;
      end else begin
         if (push && pop) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            rd_ptr_d = rd_ptr_q + 1'b1;
         end else if (push) begin
            if (!full) begin
               mem_we   = 1'b1;
               wr_ptr_d = wr_ptr_q + 1'b1;
               count_d  = count_q + 1'b1;
            end else if (mode_wrap) begin
               // Full in wrap mode: the oldest entry is overwritten in place.
               mem_we     = 1'b1;
               wr_ptr_d   = wr_ptr_q + 1'b1;
               rd_ptr_d   = rd_ptr_q + 1'b1;
               overflow_d = 1'b1;
            end else begin
               overflow_d = 1'b1;
            end
         end else if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            count_d  = count_q - 1'b1;
         end

         case (state_q)
            ST_CAPTURE: begin
               if (push && trig_en && (ret_pc == trig_pc)) begin
                  triggered_d = 1'b1;
                  if (post_cnt == '0) begin
                     state_d = ST_DONE;
                  end else begin
                     state_d  = ST_POST;
                     remain_d = post_cnt;
                  end
               end
            end
            ST_POST: begin
               if (push) begin
                  remain_d = remain_q - 1'b1;
                  if (remain_q == CW'(1)) state_d = ST_DONE;
               end
            end
            default: ;
         endcase

         if (!en && (state_q != ST_IDLE)) state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         remain_q    <= '0;
         overflow_q  <= 1'b0;
         triggered_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         remain_q    <= remain_d;
         overflow_q  <= overflow_d;
         triggered_q <= triggered_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst && mem_we) begin
         pc_mem[wr_ptr_q]    <= ret_pc;
         instr_mem[wr_ptr_q] <= ret_instr;
         wdata_mem[wr_ptr_q] <= ret_wdata;
         rd_mem[wr_ptr_q]    <= ret_rd;
         we_mem[wr_ptr_q]    <= ret_we;
      end
   end

`ifdef TRACE_TIMESTAMP_EN
   logic [CYC_W-1:0] cyc_q;
   logic [CYC_W-1:0] cyc_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (!rst) cyc_q <= '0;
      else      cyc_q <= cyc_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst && mem_we) cyc_mem[wr_ptr_q] <= cyc_q;
   end

   assign rd_cycle = cyc_mem[rd_ptr_q];
`else
   if (CYC_W < 1) begin : g_bad_cyc_w
      $error("CYC_W must be at least 1");
   end
`endif

   assign rd_valid  = (count_q != '0);
   assign rd_pc     = pc_mem[rd_ptr_q];
   assign rd_instr  = instr_mem[rd_ptr_q];
   assign rd_wdata  = wdata_mem[rd_ptr_q];
   assign rd_rd     = rd_mem[rd_ptr_q];
   assign rd_we     = we_mem[rd_ptr_q];
   assign count     = count_q;
   assign state     = state_q;
   assign overflow  = overflow_q;
   assign triggered = triggered_q;
endmodule

// File: tb/tb_retire_trace_buffer.sv
// tb/tb_retire_trace_buffer.sv - scoreboard bench for retire_trace_buffer
module tb_retire_trace_buffer;
   localparam int DEPTH = 16;
   localparam int XLEN  = 32;
   localparam int CYC_W = 32;
   localparam int CW    = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] wdata;
      logic [4:0]  rd;
      logic        we;
   } ent_t;

   logic            clk = 1'b0;
   logic            rst, en, mode_wrap, trig_en, ret_valid, ret_we, rd_ready;
   logic [XLEN-1:0] trig_pc, ret_pc, ret_instr, ret_wdata;
   logic [CW-1:0]   post_cnt;
   logic [4:0]      ret_rd;
   logic            rd_valid, rd_we, overflow, triggered;
   logic [XLEN-1:0] rd_pc, rd_instr, rd_wdata;
   logic [4:0]      rd_rd;
   logic [CW-1:0]   count;
   logic [1:0]      state;
`ifdef TRACE_TIMESTAMP_EN
   logic [CYC_W-1:0] rd_cycle;
`endif

   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   ent_t exp_q[$];

   retire_trace_buffer #(.DEPTH(DEPTH), .XLEN(XLEN), .CYC_W(CYC_W)) dut (
      .clk(clk), .rst(rst), .en(en), .mode_wrap(mode_wrap),
      .trig_en(trig_en), .trig_pc(trig_pc), .post_cnt(post_cnt),
      .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_instr(ret_instr),
      .ret_rd(ret_rd), .ret_we(ret_we), .ret_wdata(ret_wdata),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc),
      .rd_instr(rd_instr), .rd_wdata(rd_wdata), .rd_rd(rd_rd), .rd_we(rd_we),
`ifdef TRACE_TIMESTAMP_EN
      .rd_cycle(rd_cycle),
`endif
      .count(count), .state(state), .overflow(overflow), .triggered(triggered)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic ent_t make_ent(input int i);
      ent_t e;
      e.pc    = 32'(i * 4);
      e.instr = 32'h0000_0013 | 32'(i << 20);
      e.wdata = 32'hA5A5_0000 ^ 32'(i * 7 + 1);
      e.rd    = 5'(i);
      e.we    = i[0];
      return e;
   endfunction

   task automatic step();
      @(negedge clk);
      cyc++;
   endtask

   task automatic drive_ret(input int i);
      ent_t e = make_ent(i);
      ret_valid = 1'b1;
      ret_pc    = e.pc;
      ret_instr = e.instr;
      ret_wdata = e.wdata;
      ret_rd    = e.rd;
      ret_we    = e.we;
   endtask

   task automatic retire(input int i);
      drive_ret(i);
      step();
      ret_valid = 1'b0;
   endtask

   task automatic start(input logic wrap);
      exp_q.delete();
      mode_wrap = wrap;
      en = 1'b1;
      step();
      checks++;
      if ({state, count, overflow, triggered} !== {2'd1, CW'(0), 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL start: state=%0d count=%0d ovf=%b trg=%b, need 1/0/0/0", state, count, overflow, triggered);
      end
   endtask

   task automatic stop_capture();
      en = 1'b0;
      step();
      checks++;
      if (state !== 2'd0) begin
         errors++;
         $display("FAIL stop_idle: state=%0d need 0", state);
      end
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (rd_valid === 1'b1 && n < 40) begin
         ent_t e;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s extra: got pc=%h, scoreboard empty", name, rd_pc);
            break;
         end
         e = exp_q.pop_front();
         if ({rd_pc, rd_instr, rd_wdata, rd_rd, rd_we} !== e) begin
            errors++;
            $display("FAIL %s entry %0d: got pc=%h instr=%h wd=%h rd=%0d we=%b, need pc=%h instr=%h wd=%h rd=%0d we=%b",
                     name, n, rd_pc, rd_instr, rd_wdata, rd_rd, rd_we, e.pc, e.instr, e.wdata, e.rd, e.we);
         end
         rd_ready = 1'b1;
         step();
         rd_ready = 1'b0;
         n++;
      end
      checks++;
      if (exp_q.size() != 0 || rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s end: rd_valid=%b left=%0d, need 0/0", name, rd_valid, exp_q.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; en = 1'b0; mode_wrap = 1'b0; trig_en = 1'b0; trig_pc = '0;
      post_cnt = '0; ret_valid = 1'b0; ret_pc = '0; ret_instr = '0; ret_rd = '0;
      ret_we = 1'b0; ret_wdata = '0; rd_ready = 1'b0;
      step(); step();
      rst = 1'b1;
      cyc = 0;
      checks++;
      if ({state, count, rd_valid, overflow, triggered} !== {2'd0, CW'(0), 3'b000}) begin
         errors++;
         $display("FAIL reset: state=%0d count=%0d valid=%b ovf=%b trg=%b, need all 0", state, count, rd_valid, overflow, triggered);
      end
   endtask

   task automatic test_idle_ignored();
      retire(0);
      rd_ready = 1'b1;
      retire(1);
      rd_ready = 1'b0;
      checks++;
      if ({count, rd_valid, state} !== {CW'(0), 1'b0, 2'd0}) begin
         errors++;
         $display("FAIL idle_ignored: count=%0d valid=%b state=%0d, need 0/0/0", count, rd_valid, state);
      end
   endtask

   task automatic test_stop_full();
      start(1'b0);
      for (int i = 0; i < 17; i++) begin
         retire(i);
         if (i < DEPTH) exp_q.push_back(make_ent(i));
      end
      checks++;
      if ({count, overflow} !== {CW'(16), 1'b1}) begin
         errors++;
         $display("FAIL stop_full: count=%0d ovf=%b, need 16/1", count, overflow);
      end
      stop_capture();
      drain("stop_drain");
   endtask

   task automatic test_wrap();
      start(1'b1);
      for (int i = 0; i < 20; i++) begin
         retire(i);
         exp_q.push_back(make_ent(i));
         if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
      end
      checks++;
      if ({count, overflow} !== {CW'(16), 1'b1}) begin
         errors++;
         $display("FAIL wrap_full: count=%0d ovf=%b, need 16/1", count, overflow);
      end
      stop_capture();
      drain("wrap_drain");
   endtask

   task automatic test_trigger();
      trig_en = 1'b1; trig_pc = 32'h20; post_cnt = CW'(3);
      start(1'b0);
      for (int i = 0; i < 12; i++) begin
         retire(i);
         exp_q.push_back(make_ent(i));
         if (i == 7) begin
            checks++;
            if ({triggered, state} !== {1'b0, 2'd1}) begin
               errors++;
               $display("FAIL pre_trig: trg=%b state=%0d, need 0/1", triggered, state);
            end
         end
         if (i == 8) begin
            checks++;
            if ({triggered, state} !== {1'b1, 2'd2}) begin
               errors++;
               $display("FAIL trig_fire: trg=%b state=%0d, need 1/2", triggered, state);
            end
            post_cnt = CW'(0);
         end
         if (i == 10) begin
            checks++;
            if (state !== 2'd2) begin
               errors++;
               $display("FAIL post_window: state=%0d need 2", state);
            end
         end
      end
      checks++;
      if ({state, count} !== {2'd3, CW'(12)}) begin
         errors++;
         $display("FAIL trig_done: state=%0d count=%0d, need 3/12", state, count);
      end
      retire(12);
      checks++;
      if (count !== CW'(12)) begin
         errors++;
         $display("FAIL done_frozen: count=%0d need 12", count);
      end
      trig_en = 1'b0;
      stop_capture();
      drain("trig_drain");
   endtask

   task automatic test_push_pop_full();
      ent_t e;
      start(1'b0);
      for (int i = 0; i < DEPTH; i++) begin
         retire(i);
         exp_q.push_back(make_ent(i));
      end
      e = exp_q.pop_front();
      checks++;
      if ({count, overflow, rd_pc} !== {CW'(16), 1'b0, e.pc}) begin
         errors++;
         $display("FAIL pp_pre: count=%0d ovf=%b head=%h, need 16/0/%h", count, overflow, rd_pc, e.pc);
      end
      drive_ret(DEPTH);
      exp_q.push_back(make_ent(DEPTH));
      rd_ready = 1'b1;
      step();
      ret_valid = 1'b0;
      rd_ready = 1'b0;
      checks++;
      if ({count, overflow} !== {CW'(16), 1'b0}) begin
         errors++;
         $display("FAIL pp_full: count=%0d ovf=%b, need 16/0", count, overflow);
      end
      stop_capture();
      drain("pp_drain");
   endtask

   task automatic test_reset_in_post();
      trig_en = 1'b1; trig_pc = 32'h10; post_cnt = CW'(8);
      start(1'b0);
      for (int i = 0; i < 5; i++) retire(i);
      checks++;
      if ({state, count, triggered} !== {2'd2, CW'(5), 1'b1}) begin
         errors++;
         $display("FAIL post_setup: state=%0d count=%0d trg=%b, need 2/5/1", state, count, triggered);
      end
      rst = 1'b0;
      step();
      rst = 1'b1;
      cyc = 0;
      exp_q.delete();
      checks++;
      if ({state, count, rd_valid, triggered, overflow} !== {2'd0, CW'(0), 3'b000}) begin
         errors++;
         $display("FAIL post_reset: state=%0d count=%0d valid=%b trg=%b ovf=%b, need all 0", state, count, rd_valid, triggered, overflow);
      end
      trig_en = 1'b0;
      en = 1'b0;
      step();
   endtask

`ifdef TRACE_TIMESTAMP_EN
   task automatic test_timestamp();
      logic [CYC_W-1:0] cyc_exp[$];
      int n = 0;
      rst = 1'b0;
      step();
      rst = 1'b1;
      cyc = 0;
      exp_q.delete();
      en = 1'b1; mode_wrap = 1'b0; trig_en = 1'b0;
      for (int t = 0; t < 9; t++) begin
         if (cyc == 3 || cyc == 4 || cyc == 7) begin
            drive_ret(t);
            exp_q.push_back(make_ent(t));
            cyc_exp.push_back(CYC_W'(cyc));
         end else begin
            ret_valid = 1'b0;
         end
         step();
      end
      ret_valid = 1'b0;
      stop_capture();
      while (rd_valid === 1'b1 && n < 10) begin
         ent_t e;
         logic [CYC_W-1:0] c;
         checks++;
         if (cyc_exp.size() == 0) begin
            errors++;
            $display("FAIL ts extra: got cycle=%0d, scoreboard empty", rd_cycle);
            break;
         end
         c = cyc_exp.pop_front();
         e = exp_q.pop_front();
         if ({rd_cycle, rd_pc} !== {c, e.pc}) begin
            errors++;
            $display("FAIL ts entry %0d: cycle=%0d pc=%h, need cycle=%0d pc=%h", n, rd_cycle, rd_pc, c, e.pc);
         end
         rd_ready = 1'b1;
         step();
         rd_ready = 1'b0;
         n++;
      end
      checks++;
      if (n != 3) begin
         errors++;
         $display("FAIL ts count: popped %0d need 3", n);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_idle_ignored();
      test_stop_full();
      test_wrap();
      test_trigger();
      test_push_pop_full();
      test_reset_in_post();
`ifdef TRACE_TIMESTAMP_EN
      test_timestamp();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
